// File: rtl/lcd_controller.sv
// HD44780-style character LCD controller: power-up init, character/command writes and line wrap.
// Define LCD_NEWLINE_EN to treat data byte 0x0A as a newline instead of a printed glyph.
module lcd_controller #(
    parameter int CLK_HZ     = 10_000_000,
    parameter int BUS_WIDTH  = 8,
    parameter int ROWS       = 2,
    parameter int COLS       = 16,
    parameter int POWERUP_US = 50000,
    parameter int CMD_US     = 50,
    parameter int CLEAR_US   = 2000,
    parameter int E_CYC      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_data,
    input  logic       char_is_cmd,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);
    localparam int MHZ = CLK_HZ / 1_000_000;
    // The fixed 4100 us init wait shares the counter, so it also bounds the width.
    localparam int BIG_US  = (POWERUP_US > CLEAR_US) ? POWERUP_US : CLEAR_US;
    localparam int MAX_US  = (BIG_US > 4100) ? BIG_US : 4100;
    localparam int MAX_CYC = (MAX_US * MHZ > E_CYC) ? MAX_US * MHZ : E_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PWR_LIM   = CW'(POWERUP_US * MHZ - 1);
    localparam logic [CW-1:0] CMD_LIM   = CW'(CMD_US * MHZ - 1);
    localparam logic [CW-1:0] CLEAR_LIM = CW'(CLEAR_US * MHZ - 1);
    localparam logic [CW-1:0] W4100_LIM = CW'(4100 * MHZ - 1);
    localparam logic [CW-1:0] W100_LIM  = CW'(100 * MHZ - 1);
    localparam logic [CW-1:0] E_LIM     = CW'(E_CYC - 1);

    localparam logic [7:0] FUNC_SET  = ((BUS_WIDTH == 4) ? 8'h20 : 8'h30) | ((ROWS == 1) ? 8'h00 : 8'h08);
    localparam logic [3:0] INIT_END  = (BUS_WIDTH == 4) ? 4'd9 : 4'd8;
    localparam logic [5:0] COL_LAST  = 6'(COLS - 1);
    localparam logic [1:0] ROW_LAST  = 2'(ROWS - 1);

`ifdef LCD_NEWLINE_EN
    localparam bit NEWLINE_EN = 1'b1;
`else
    localparam bit NEWLINE_EN = 1'b0;
`endif

    localparam logic [2:0] PWR_WAIT  = 3'd0;
    localparam logic [2:0] INIT      = 3'd1;
    localparam logic [2:0] IDLE      = 3'd2;
    localparam logic [2:0] WRAP      = 3'd3;
    localparam logic [2:0] SETUP     = 3'd4;
    localparam logic [2:0] E_HIGH    = 3'd5;
    localparam logic [2:0] E_HOLD    = 3'd6;
    localparam logic [2:0] EXEC_WAIT = 3'd7;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wait_lim;
    logic [3:0]    init_step;
    logic [3:0]    init_k;
    logic [3:0]    tx_low;
    logic          low_pending;
    logic          is_data;
    logic [1:0]    row;
    logic [1:0]    next_row;
    logic [5:0]    col;
    logic [7:0]    row_base;
    logic [7:0]    init_byte;
    logic [CW-1:0] init_wait;
    logic          init_single;
    logic          accept;
    logic          is_clear;
    logic          is_newline;
    logic          launch;
    logic [7:0]    l_byte;
    logic          l_rs;
    logic [CW-1:0] l_wait;
    logic          l_single;

    assign char_ready = (state == IDLE) && init_done;
    assign lcd_rw     = 1'b0;
    assign accept     = char_valid && char_ready;
    assign is_clear   = char_is_cmd && ((char_data == 8'h01) || (char_data == 8'h02));
    assign is_newline = NEWLINE_EN && !char_is_cmd && (char_data == 8'h0A);
    assign next_row   = (row == ROW_LAST) ? 2'd0 : row + 2'd1;

    // The 8-bit build skips the lone 0x20 nibble by stepping over table slot 3.
    always_comb begin
        init_k = init_step;
        if (BUS_WIDTH != 4 && init_step >= 4'd3)
            init_k = init_step + 4'd1;
        init_byte   = 8'h30;
        init_wait   = CMD_LIM;
        init_single = 1'b0;
        case (init_k)
            4'd0: begin init_wait = W4100_LIM; init_single = 1'b1; end
            4'd1: begin init_wait = W100_LIM;  init_single = 1'b1; end
            4'd2: init_single = 1'b1;
            4'd3: begin init_byte = 8'h20; init_single = 1'b1; end
            4'd4: init_byte = FUNC_SET;
            4'd5: init_byte = 8'h08;
            4'd6: begin init_byte = 8'h01; init_wait = CLEAR_LIM; end
            4'd7: init_byte = 8'h06;
            default: init_byte = 8'h0C;
        endcase
    end

    always_comb begin
        case (row)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'(COLS);
            default: row_base = 8'(64 + COLS);
        endcase
    end

    // Every state that starts a bus byte funnels through one launch request.
    always_comb begin
        launch   = 1'b0;
        l_byte   = char_data;
        l_rs     = 1'b0;
        l_wait   = CMD_LIM;
        l_single = 1'b0;
        case (state)
            INIT: if (init_step != INIT_END) begin
                launch   = 1'b1;
                l_byte   = init_byte;
                l_wait   = init_wait;
                l_single = init_single;
            end
            IDLE: if (accept && !is_newline) begin
                launch = 1'b1;
                l_rs   = !char_is_cmd;
                if (is_clear)
                    l_wait = CLEAR_LIM;
            end
            WRAP: begin
                launch = 1'b1;
                l_byte = 8'h80 | row_base;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= PWR_WAIT;
            cnt         <= '0;
            wait_lim    <= '0;
            init_step   <= '0;
            tx_low      <= '0;
            low_pending <= 1'b0;
            is_data     <= 1'b0;
            row         <= '0;
            col         <= '0;
            init_done   <= 1'b0;
            lcd_data    <= '0;
            lcd_rs      <= 1'b0;
            lcd_e       <= 1'b0;
        end else begin
            case (state)
                PWR_WAIT:
                    if (cnt == PWR_LIM) begin
                        cnt   <= '0;
                        state <= INIT;
                    end else
                        cnt <= cnt + CW'(1);
                INIT:
                    if (init_step == INIT_END) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else
                        init_step <= init_step + 4'd1;
                IDLE:
                    if (accept) begin
                        is_data <= !char_is_cmd;
                        if (is_clear) begin
                            row <= '0;
                            col <= '0;
                        end else if (is_newline) begin
                            col   <= '0;
                            row   <= next_row;
                            state <= WRAP;
                        end
                    end
                WRAP: is_data <= 1'b0;
                SETUP: begin
                    lcd_e <= 1'b1;
                    cnt   <= '0;
                    state <= E_HIGH;
                end
                E_HIGH:
                    if (cnt == E_LIM) begin
                        cnt   <= '0;
                        lcd_e <= 1'b0;
                        state <= E_HOLD;
                    end else
                        cnt <= cnt + CW'(1);
                E_HOLD:
                    if (cnt == E_LIM) begin
                        cnt <= '0;
                        if (low_pending) begin
                            lcd_data    <= {tx_low, 4'h0};
                            low_pending <= 1'b0;
                            state       <= SETUP;
                        end else
                            state <= EXEC_WAIT;
                    end else
                        cnt <= cnt + CW'(1);
                EXEC_WAIT:
                    if (cnt == wait_lim) begin
                        cnt <= '0;
                        if (!init_done)
                            state <= INIT;
                        else if (is_data && col == COL_LAST) begin
                            col   <= '0;
                            row   <= next_row;
                            state <= WRAP;
                        end else begin
                            if (is_data)
                                col <= col + 6'd1;
                            state <= IDLE;
                        end
                    end else
                        cnt <= cnt + CW'(1);
                default: state <= PWR_WAIT;
            endcase
            if (launch) begin
                lcd_data    <= (BUS_WIDTH == 4) ? {l_byte[7:4], 4'h0} : l_byte;
                lcd_rs      <= l_rs;
                tx_low      <= l_byte[3:0];
                low_pending <= (BUS_WIDTH == 4) && !l_single;
                wait_lim    <= l_wait;
                cnt         <= '0;
                state       <= SETUP;
            end
        end
    end
endmodule

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10_000_000, clock frequency in Hz, an integer multiple of 1_000_000.
REQ-002 SHALL have parameter BUS_WIDTH, default 8, LCD data bus mode, legal values 8 or 4.
REQ-003 SHALL have parameter ROWS, default 2, display rows, legal values 1, 2 or 4.
REQ-004 SHALL have parameter COLS, default 16, characters per row, range 8..40.
REQ-005 SHALL have parameter POWERUP_US, default 50000, power-on wait in microseconds.
REQ-006 SHALL have parameter CMD_US, default 50, execution wait for data writes and non-clear commands, in microseconds.
REQ-007 SHALL have parameter CLEAR_US, default 2000, execution wait after 0x01 and 0x02, in microseconds.
REQ-008 SHALL have parameter E_CYC, default 5, lcd_e high width and hold width in clocks, minimum 1.
REQ-009 SHALL have ports, with clock and reset first:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- char_data  in  8  ASCII character or raw instruction.
- char_is_cmd  in  1  1 sends char_data as an instruction (rs=0).
- char_valid  in  1  request.
- char_ready  out  1  accept.
- init_done  out  1  init sequence complete.
- lcd_data  out  8  LCD bus; in 4-bit mode only [7:4] is used and [3:0] is driven 0.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  read/write; always 0.
- lcd_e  out  1  enable strobe; the LCD latches on its falling edge.

Function
REQ-010 SHALL derive all waits as N_us*(CLK_HZ/1_000_000) clocks, using one counter wide enough for max(POWERUP_US, CLEAR_US).
REQ-011 SHALL use states PWR_WAIT, INIT, IDLE, WRAP, SETUP, E_HIGH, E_HOLD and EXEC_WAIT.
REQ-012 SHALL, for each bus transfer, run the sequence below; lcd_data and lcd_rs are stable from SETUP through E_HOLD.
- SETUP: 1 clock.
- E_HIGH: lcd_e=1 for E_CYC clocks.
- E_HOLD: lcd_e=0 for E_CYC clocks.
REQ-013 SHALL, in 4-bit mode, send each byte as two transfers, high nibble then low nibble, with no execution wait between the nibbles.
REQ-014 SHALL run the init sequence in this order:
- Wait POWERUP_US.
- Send nibble/byte 0x30, then wait 4100 us.
- Send 0x30, then wait 100 us.
- Send 0x30, then wait CMD_US.
- 4-bit mode only: send the single nibble 0x20.
- Send function set: 0x38 in 8-bit mode or 0x28 in 4-bit mode, with N=0 when ROWS=1.
- Send 0x08, then 0x01 (wait CLEAR_US), 0x06 and 0x0C.
REQ-015 SHALL, after the REQ-014 sequence completes, assert init_done and hold it until reset.
REQ-016 SHALL drive char_ready=1 only in IDLE with init_done=1.
REQ-017 SHALL accept a request only when char_valid&&char_ready; it then captures char_data and char_is_cmd, and char_ready is 0 on the next clock.
REQ-018 SHALL send a data byte (rs=1) followed by a CMD_US wait, then increment col.
REQ-019 SHALL, when col reaches COLS, reset col to 0, increment row (ROWS-1 wraps to 0), and enter WRAP.
REQ-020 SHALL, in WRAP, send set-DDRAM 0x80|base[row] before returning to IDLE, with base = 0x00, 0x40, 0x00+COLS and 0x40+COLS.
REQ-021 SHALL send a command byte (rs=0); 0x01 and 0x02 use CLEAR_US and reset row and col to 0, and all other commands use CMD_US and leave row and col unchanged.
REQ-022 SHALL ignore char_valid while char_ready=0, with no queuing.

Reset
REQ-023 SHALL, on rst_n=0 at a clk edge, set the outputs to these values on that edge:
- lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_e=0.
- char_ready=0, init_done=0.
- row=0, col=0.
REQ-024 SHALL, on reset, enter PWR_WAIT with the counter cleared, including mid-transfer or mid-wait, so the full power-up and init sequence reruns.

Configuration
REQ-025 SHALL, when macro LCD_NEWLINE_EN is defined, treat a data request of 0x0A as newline: no data byte is sent, col=0, row advances with wrap, and the WRAP address command is issued.
REQ-026 SHALL, without LCD_NEWLINE_EN, send 0x0A as an ordinary data byte.

Verification
REQ-027 SHALL, with CLK_HZ=1_000_000, POWERUP_US=100, BUS_WIDTH=8, ROWS=2 and COLS=16, capture on lcd_e falls after reset the bytes 30,30,30,38,08,01,06,0C, and assert init_done after the last wait.
REQ-028 SHALL, with BUS_WIDTH=4, capture the nibbles 3,3,3,2,2,8,0,8,0,1,0,6,0,C on lcd_data[7:4], with lcd_data[3:0]=0 throughout.
REQ-029 SHALL, after writing 16 chars 'A' (0x41), show 16 rs=1 transfers, then rs=0 0xC0; the 17th char is accepted only after the 0xC0 wait.
REQ-030 SHALL, after 32 chars on 2x16, emit 0x80 (row wrap to 0), and a following cmd 0x01 gives CLEAR_US wait with row/col=0.
REQ-031 SHALL, on rst_n pulsed low during E_HIGH of a data write, force lcd_e=0 on the next edge and restart the init byte sequence from 0x30 after POWERUP_US.
REQ-032 SHALL, with LCD_NEWLINE_EN, convert 'H',0x0A,'I' into 48 (rs=1), C0 (rs=0), 49 (rs=1); without it, they give 48, 0A, 49, all rs=1.
